// File: rtl/quad_pkg.sv
// Shared constants and types for the quad SHA-1 slot scheduler.
// Used by quad_sched and rr_arb.
package quad_pkg;

    localparam int SLOT_LEN     = 20;
    localparam int MSG_WORDS    = 5;
    localparam int QUAD_LATENCY = 83;
    localparam int PIPE_SLOTS   = 5;
    localparam int DIN_FIRST    = 2;
    localparam int CNT_W        = 5;
    localparam int TAG_ID_W     = 3;

    typedef bit [159:0] msg_t;

    typedef struct packed {
        logic                busy;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/quad_sched_rr_arb.sv
// Round-robin arbiter: first request at or after the pointer wins.
// The pointer moves past the winner when adv_en is high.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            adv_en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Descending offset so the nearest request is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ((int'(ptr_q) + k) % NREQ) == i) begin
                    idx = ID_W'(i);
                    any = 1'b1;
                end
            end
        end
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = any && (idx == ID_W'(i));
        end
        ptr_d = ptr_q;
        if (adv_en && any) begin
            ptr_d = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/quad_sched.sv
// Slot scheduler / result collector for one quad SHA-1 pipeline.
// Optional QUAD_SCHED_STATS_EN adds issued/bubble slot counters.
module quad_sched
    import quad_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][159:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  phase_advance,
    output logic [31:0]           Din,
    input  logic [31:0]           R,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output msg_t                  res_data
`ifdef QUAD_SCHED_STATS_EN
    ,
    output logic [31:0]           stat_busy,
    output logic [31:0]           stat_idle
`endif
);

    // Outputs are loaded one cycle ahead, so cnt_q leads the frame by one.
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] DIN_LO = CNT_W'(DIN_FIRST);
    localparam logic [CNT_W-1:0] DIN_HI = CNT_W'(DIN_FIRST + MSG_WORDS - 1);
    localparam int               COL_A  = (DIN_FIRST + QUAD_LATENCY) % SLOT_LEN + 1;
    localparam logic [CNT_W-1:0] COL_LO = CNT_W'(COL_A);
    localparam logic [CNT_W-1:0] COL_HI = CNT_W'(COL_A + MSG_WORDS - 1);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NREQ-1:0]             rdy_q, rdy_d;
    logic [ID_W-1:0]             gidx_q, gidx_d;
    logic                        pa_q, pa_d;
    logic [31:0]                 din_q, din_d;
    msg_t                        issue_q, issue_d;
    tag_t [PIPE_SLOTS-1:0]       tags_q, tags_d;
    msg_t                        coll_q, coll_d;
    logic                        rv_q, rv_d;
    logic [ID_W-1:0]             rid_q, rid_d;
    msg_t                        rdata_q, rdata_d;

    logic                        at_last;
    logic [NREQ-1:0]             arb_gnt;
    logic [ID_W-1:0]             arb_idx;
    logic                        arb_any;
    msg_t                        sel_msg;
    tag_t                        new_tag;

    assign at_last = (cnt_q == LAST);

    rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .adv_en (at_last),
        .gnt    (arb_gnt),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        cnt_d   = at_last ? '0 : cnt_q + 1'b1;
        rdy_d   = at_last ? arb_gnt : '0;
        gidx_d  = (at_last && arb_any) ? arb_idx : gidx_q;
        pa_d    = (cnt_q == '0);
        din_d   = '0;
        issue_d = issue_q;
        tags_d  = tags_q;
        coll_d  = coll_q;
        rv_d    = 1'b0;
        rid_d   = rid_q;
        rdata_d = rdata_q;

        sel_msg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx_q == ID_W'(i)) begin
                sel_msg = req_data[i];
            end
        end
        new_tag.busy = |rdy_q;
        new_tag.id   = TAG_ID_W'(gidx_q);

        if (cnt_q == '0) begin
            issue_d = (|rdy_q) ? sel_msg : '0;
            tags_d  = {tags_q[PIPE_SLOTS-2:0], new_tag};
        end
        if (cnt_q >= DIN_LO && cnt_q <= DIN_HI) begin
            din_d   = issue_q[159:128];
            issue_d = {issue_q[127:0], 32'h0};
        end
        if (cnt_q >= COL_LO && cnt_q <= COL_HI) begin
            coll_d = {coll_q[127:0], R};
        end
        if (cnt_q == COL_HI && tags_q[PIPE_SLOTS-1].busy) begin
            rv_d    = 1'b1;
            rid_d   = ID_W'(tags_q[PIPE_SLOTS-1].id);
            rdata_d = {coll_q[127:0], R};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            rdy_q   <= '0;
            gidx_q  <= '0;
            pa_q    <= 1'b0;
            din_q   <= '0;
            issue_q <= '0;
            tags_q  <= '0;
            coll_q  <= '0;
            rv_q    <= 1'b0;
            rid_q   <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            gidx_q  <= gidx_d;
            pa_q    <= pa_d;
            din_q   <= din_d;
            issue_q <= issue_d;
            tags_q  <= tags_d;
            coll_q  <= coll_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready     = rdy_q;
    assign phase_advance = pa_q;
    assign Din           = din_q;
    assign res_valid     = rv_q;
    assign res_id        = rid_q;
    assign res_data      = rdata_q;

`ifdef QUAD_SCHED_STATS_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] idle_q, idle_d;

    always_comb begin
        busy_d = busy_q;
        idle_d = idle_q;
        if (at_last) begin
            if (arb_any) busy_d = busy_q + 32'd1;
            else         idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            idle_q <= '0;
        end else begin
            busy_q <= busy_d;
            idle_q <= idle_d;
        end
    end

    assign stat_busy = busy_q;
    assign stat_idle = idle_q;
`endif

endmodule

// File: tb/tb_quad_sched.sv
// Bench for quad_sched with a slot-level scheduler model and a
// behavioural quad stand-in (fixed word transform, 83-cycle delay).
module tb_quad_sched;

    localparam int NREQ = 4;
    localparam int ID_W = 3;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0][159:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   phase_advance;
    logic [31:0]            Din;
    logic [31:0]            R = '0;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [159:0]           res_data;
`ifdef QUAD_SCHED_STATS_EN
    logic [31:0]            stat_busy;
    logic [31:0]            stat_idle;
    int                     m_busy = 0;
    int                     m_idle = 0;
`endif

    always #5 clk = ~clk;

    quad_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .phase_advance (phase_advance),
        .Din           (Din),
        .R             (R),
        .res_valid     (res_valid),
        .res_id        (res_id),
        .res_data      (res_data)
`ifdef QUAD_SCHED_STATS_EN
        ,
        .stat_busy     (stat_busy),
        .stat_idle     (stat_idle)
`endif
    );

    typedef struct {
        int           due;
        int           id;
        logic [159:0] data;
    } exp_t;

    int           total = 0;
    int           fails = 0;
    int           t = 0;
    int           abs_cyc = 0;
    int           ptr = 0;
    bit           issue_busy = 0;
    logic [159:0] issue_msg = '0;
    exp_t         expq[$];
    logic [31:0]  hist[128];
    bit           granted[NREQ];
    logic [NREQ-1:0] want = '0;
    bit           rand_mode = 0;

    function automatic logic [31:0] g(input logic [31:0] w);
        return ~w ^ {w[26:0], w[31:27]};
    endfunction

    function automatic logic [159:0] quad_ref(input logic [159:0] m);
        logic [159:0] o;
        for (int j = 0; j < 5; j++) o[159-32*j -: 32] = g(m[159-32*j -: 32]);
        return o;
    endfunction

    function automatic logic [159:0] rand160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic quad_tick();
        hist[abs_cyc % 128] = Din;
        R = (abs_cyc >= 83) ? g(hist[(abs_cyc - 83) % 128]) : g(32'h0);
        abs_cyc++;
    endtask

    task automatic arbitrate(output logic [NREQ-1:0] rdy);
        int gsel = -1;
        rdy = '0;
        for (int k = 0; k < NREQ; k++) begin
            int i = (ptr + k) % NREQ;
            if (gsel < 0 && req_valid[i]) gsel = i;
        end
        issue_busy = (gsel >= 0);
        issue_msg  = '0;
        if (gsel >= 0) begin
            exp_t e;
            rdy[gsel]     = 1'b1;
            granted[gsel] = 1'b1;
            issue_msg     = req_data[gsel];
            ptr           = (gsel + 1) % NREQ;
            e.due  = t + 91;
            e.id   = gsel;
            e.data = quad_ref(req_data[gsel]);
            expq.push_back(e);
        end
`ifdef QUAD_SCHED_STATS_EN
        if (gsel >= 0) m_busy++;
        else           m_idle++;
`endif
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            bit was = granted[i];
            granted[i] = 0;
            if (was) req_data[i] = rand160();
            if (rand_mode) begin
                if (was || !req_valid[i]) req_valid[i] = 1'($urandom_range(0, 1));
            end else begin
                req_valid[i] = want[i];
            end
        end
    endtask

    task automatic step();
        int              ph;
        logic [31:0]     exp_din;
        logic [NREQ-1:0] exp_rdy;
        bit              exp_rv;
        @(negedge clk);
        ph = t % 20;
        check("phase_advance", phase_advance, ph == 0);
        exp_din = '0;
        if (issue_busy && ph >= 2 && ph <= 6) exp_din = issue_msg[159-32*(ph-2) -: 32];
        check("din", Din, exp_din);
        exp_rdy = '0;
        if (ph == 19) arbitrate(exp_rdy);
        check("req_ready", req_ready, exp_rdy);
        exp_rv = (expq.size() > 0) && (expq[0].due == t);
        check("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            check("res_id", res_id, expq[0].id);
            check("res_data", res_data, expq[0].data);
            void'(expq.pop_front());
        end
`ifdef QUAD_SCHED_STATS_EN
        if (ph == 0) begin
            check("stat_busy", stat_busy, m_busy);
            check("stat_idle", stat_idle, m_idle);
        end
`endif
        quad_tick();
        if (ph == 0) drive_reqs();
        t++;
    endtask

    task automatic run_slots(input int n);
        repeat (n * 20) step();
    endtask

    task automatic pulse_reset(input int n);
        reset     = 1'b1;
        req_valid = '0;
        repeat (n) begin
            @(negedge clk);
            check("rst_phase_advance", phase_advance, 1'b0);
            check("rst_din", Din, 32'h0);
            check("rst_req_ready", req_ready, '0);
            check("rst_res_valid", res_valid, 1'b0);
            check("rst_res_id", res_id, '0);
            check("rst_res_data", res_data, '0);
`ifdef QUAD_SCHED_STATS_EN
            check("rst_stat_busy", stat_busy, 32'h0);
            check("rst_stat_idle", stat_idle, 32'h0);
`endif
            quad_tick();
        end
        reset      = 1'b0;
        t          = 0;
        ptr        = 0;
        issue_busy = 0;
        issue_msg  = '0;
        expq.delete();
        for (int i = 0; i < NREQ; i++) granted[i] = 0;
`ifdef QUAD_SCHED_STATS_EN
        m_busy = 0;
        m_idle = 0;
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) hist[i] = '0;
        for (int i = 0; i < NREQ; i++) begin
            granted[i]  = 0;
            req_data[i] = rand160();
        end

        pulse_reset(3);
        want = '0;
        run_slots(10);

        req_data[2] = 160'h61626380_00000000_00000000_00000000_00000018;
        want = 4'b0100;
        run_slots(1);
        want = '0;
        run_slots(6);

        want = 4'b1111;
        run_slots(40);
        want = '0;
        run_slots(6);

        want = 4'b0010;
        run_slots(12);
        want = '0;
        run_slots(6);

        want = 4'b1000;
        run_slots(3);
        repeat (11) step();
        pulse_reset(1);
        want = 4'b0001;
        run_slots(1);
        want = '0;
        run_slots(6);

        rand_mode = 1;
        run_slots(40);
        rand_mode = 0;
        want = '0;
        run_slots(6);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/quad_sched.md
# quad_sched

Slot scheduler and result collector for the four-way interleaved SHA-1 `quad` pipeline. It runs `quad` on a fixed 20-cycle slot frame and shares its input between `NREQ` requesters using round-robin arbitration. Granted 160-bit messages are streamed into `Din`, and each 160-bit result on `R` is returned with the originating requester index. The block sits between the search front-ends and one `quad` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ID_W`, 3: width of the requester index, at least ceil(log2(`NREQ`)).
- `clk` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `req_valid` input `NREQ`: requester i has a message pending.
- `req_data` input `NREQ`x160: message per requester; word 0 = bits [159:128].
- `req_ready` output `NREQ`: one-cycle grant/accept pulse.
- `phase_advance` output 1: to `quad.phase_advance`.
- `Din` output 32: to `quad.Din`.
- `R` input 32: from `quad.R`.
- `res_valid` output 1: one-cycle result pulse; no backpressure.
- `res_id` output `ID_W`: requester index of the result.
- `res_data` output 160: result; word 0 = bits [159:128].

## Operation
- Slot counter `cnt` runs 0..19 and wraps. It is 0 in the first cycle after `reset` deasserts.
- `phase_advance` is high exactly when `cnt`==0. It is periodic and runs even when no requests are pending, because `quad` needs an unbroken frame.
- Arbitration happens at `cnt`==19:
  - Among `req_valid`, grant the first index at or after the round-robin pointer. The pointer is 0 after reset.
  - Assert `req_ready[g]` in that cycle and capture `req_data[g]` into the issue register.
  - Move the pointer to g+1 mod `NREQ`.
  - No valid requests means the slot is a bubble.
- Issue: at `cnt` 2..6 of the following slot, drive `Din` with words 0..4 of the issue register. At all other `cnt` values, and during bubbles, `Din`=0.
- Tag delay line:
  - 5 entries of {`busy`, `id`}, shifted at `cnt`==0.
  - Bubbles and the reset value are `busy`=0.
  - The entry issued in slot k is examined in slot k+4.
- Collect: at `cnt` 5..9 of slot k+4, shift `R` into the result register (word 0 first).
- Result output:
  - If the examined entry is `busy`, then at `cnt`==10 pulse `res_valid` with `res_id` and `res_data`.
  - A bubble never produces `res_valid`.
- A requester holding `req_valid` high receives at most one `req_ready` per slot. `req_data` must be stable during the cycle `req_ready` is high.
- Mid-operation `reset`:
  - Clears `cnt`, the pointer and every delay-line entry.
  - Results still in flight inside `quad` are discarded silently; no `res_valid` is produced for them.
- `quad` has no reset. Its unit rotation is irrelevant here because results are tracked by slot time only.

## Timing
- Reset values: `phase_advance`=0, `Din`=0, `req_ready`=0, `res_valid`=0, `res_id`=0, `res_data`=0.
- All outputs are registered.
- Grant to `phase_advance`: 1 cycle.
- `phase_advance` to first `Din` word: 2 cycles.
- First `Din` word to first `R` word: 83 cycles.
- Grant to `res_valid`: 91 cycles.
- Throughput: one message per 20 cycles; at most 5 messages in flight.
- Back-to-back grants to the same requester are allowed in consecutive slots.

## Configuration
- `QUAD_SCHED_STATS_EN` defined adds two outputs:
  - `stat_busy`: 32-bit count of issued slots.
  - `stat_idle`: 32-bit count of bubble slots.
  - Both update at `cnt`==19, wrap modulo 2^32, and are reset to 0.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `quad_pkg`:
  - `SLOT_LEN`=20, `MSG_WORDS`=5, `QUAD_LATENCY`=83, `PIPE_SLOTS`=5.
  - Typedef `msg_t` (bit [159:0]) and the delay-line entry struct.
- One sub-module, `rr_arb`: parameterised round-robin arbiter with `NREQ` request bits in, a one-hot grant plus index out, and a pointer-advance enable.
- Slot counter, issue shifter, delay line and collector live in `quad_sched`.

## Test plan
- Idle after reset, 200 cycles: `phase_advance` high at cycles 0, 20, 40…; `Din` always 0; no `res_valid`.
- Single request from requester 2 with message "abc" padded to 160 bits: `res_valid` with `res_id`=2 exactly 91 cycles after `req_ready`; `res_data` equals the behavioural `quad` model output.
- All four requesters continuously valid for 40 slots: grants go 0,1,2,3,0…, one per slot; results return in grant order with matching ids, 20 cycles apart.
- Requester 1 only, continuously valid: grants every slot with no bubbles; 5 results outstanding at steady state.
- `reset` asserted for 1 cycle while 3 messages are in flight: no `res_valid` for them; a new grant at the first `cnt`==19 after reset; its result is correct.
- With `QUAD_SCHED_STATS_EN`, 10 issued slots and 6 idle slots: `stat_busy`=10, `stat_idle`=6.
